sar_scan_sequencer: RTL and testbench

- Controller for the 8-bit SAR conversion core. Scans a set of analog input channels, selects each enabled channel, holds the sample window, starts one SAR conversion, and collects the result.
- Delivers each result with its channel tag through a single-entry valid/ready output register.
- Sits between the top-level wrapper pins (channel mask, trigger) and the SAR core's start/done/result interface.

---
 rtl/sar_scan_sequencer.sv | 161 ++++++++++++++++
 tb/tb_sar_scan_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_scan_sequencer.sv
// rtl/sar_scan_sequencer.sv - channel scan sequencer for the 8-bit SAR core
// Optional conversion watchdog enabled by defining SAR_WDOG_EN.
module sar_scan_sequencer #(
    parameter int NUM_CH        = 4,
    parameter int CH_W          = 2,
    parameter int SAMPLE_CYCLES = 4,
    parameter int RES_W         = 8,
    parameter int WDOG_CYCLES   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              continuous,
    input  logic              trig,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic [CH_W-1:0]   ch_sel,
    output logic              sample,
    output logic              sar_start,
    input  logic              sar_done,
    input  logic [RES_W-1:0]  sar_result,
    output logic [RES_W-1:0]  res_data,
    output logic [CH_W-1:0]   res_ch,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              busy,
    output logic              overrun,
    output logic              timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_SAMPLE,
        S_CONVERT,
        S_STORE
    } state_t;

    state_t            state_q, state_d;
    logic [NUM_CH-1:0] scan_mask;
    logic [CH_W:0]     ch_ptr;
    logic [3:0]        smp_cnt;
    logic [RES_W-1:0]  cap_data;
    logic [CH_W-1:0]   cap_ch;
    logic              found;
    logic [CH_W-1:0]   found_idx;
    logic              scan_go;
    logic              sample_done;
    logic              wdog_expire;

    assign scan_go     = enable & (trig | continuous);
    assign sample_done = (smp_cnt == 4'(SAMPLE_CYCLES));
    assign sample      = (state_q == S_SAMPLE) && !sample_done;
    assign sar_start   = (state_q == S_SAMPLE) && sample_done;
    assign busy        = (state_q != S_IDLE);

    // Descending walk so the lowest qualifying index is the one left standing.
    always_comb begin
        found     = 1'b0;
        found_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (scan_mask[i] && (i >= int'(ch_ptr))) begin
                found     = 1'b1;
                found_idx = CH_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (scan_go) state_d = S_SELECT;
            S_SELECT:  state_d = (found && enable) ? S_SAMPLE : S_IDLE;
            S_SAMPLE:  if (sample_done) state_d = S_CONVERT;
            S_CONVERT: begin
                if (sar_done)
                    state_d = S_STORE;
                else if (wdog_expire)
                    state_d = S_SELECT;
            end
            S_STORE:   state_d = S_SELECT;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_mask <= '0;
            ch_ptr    <= '0;
            ch_sel    <= '0;
            smp_cnt   <= '0;
            cap_data  <= '0;
            cap_ch    <= '0;
            res_data  <= '0;
            res_ch    <= '0;
            res_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (state_q == S_IDLE && scan_go) begin
                scan_mask <= ch_mask;
                ch_ptr    <= '0;
            end
            if (state_q == S_SELECT && found && enable) begin
                ch_sel             <= found_idx;
                scan_mask[found_idx] <= 1'b0;
                ch_ptr             <= {1'b0, found_idx} + (CH_W + 1)'(1);
                smp_cnt            <= '0;
            end
            if (state_q == S_SAMPLE && !sample_done)
                smp_cnt <= smp_cnt + 4'd1;
            if (state_q == S_CONVERT && sar_done) begin
                cap_data <= sar_result;
                cap_ch   <= ch_sel;
            end
            // A reload in the accept cycle keeps valid high and is not an overrun.
            if (state_q == S_STORE) begin
                res_data  <= cap_data;
                res_ch    <= cap_ch;
                res_valid <= 1'b1;
                if (res_valid && !res_ready)
                    overrun <= 1'b1;
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

`ifdef SAR_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);
    logic [WD_W-1:0] wdog_cnt;
    logic            timeout_q;

    // Counter reads k in the k-th CONVERT cycle after the start pulse.
    assign wdog_expire = (state_q == S_CONVERT) && (wdog_cnt == WD_W'(WDOG_CYCLES - 1));
    assign timeout     = timeout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (sar_start)
                wdog_cnt <= WD_W'(1);
            else if (state_q == S_CONVERT)
                wdog_cnt <= wdog_cnt + WD_W'(1);
            if (wdog_expire && !sar_done)
                timeout_q <= 1'b1;
        end
    end
`else
    assign wdog_expire = 1'b0;
    assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_sar_scan_sequencer.sv
// tb/tb_sar_scan_sequencer.sv - scoreboard bench for sar_scan_sequencer
// Watchdog scenario runs only when SAR_WDOG_EN is defined.
module tb_sar_scan_sequencer;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    localparam int RES_W  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic              continuous;
    logic              trig;
    logic [NUM_CH-1:0] ch_mask;
    logic [CH_W-1:0]   ch_sel;
    logic              sample;
    logic              sar_start;
    logic              sar_done;
    logic [RES_W-1:0]  sar_result;
    logic [RES_W-1:0]  res_data;
    logic [CH_W-1:0]   res_ch;
    logic              res_valid;
    logic              res_ready;
    logic              busy;
    logic              overrun;
    logic              timeout;

    sar_scan_sequencer #(
        .NUM_CH(NUM_CH), .CH_W(CH_W), .SAMPLE_CYCLES(4), .RES_W(RES_W), .WDOG_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .continuous(continuous), .trig(trig),
        .ch_mask(ch_mask), .ch_sel(ch_sel), .sample(sample), .sar_start(sar_start),
        .sar_done(sar_done), .sar_result(sar_result), .res_data(res_data),
        .res_ch(res_ch), .res_valid(res_valid), .res_ready(res_ready), .busy(busy),
        .overrun(overrun), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [CH_W+RES_W-1:0] exp_res_q[$];
    logic [CH_W-1:0]       exp_ch_q[$];
    logic [RES_W-1:0]      code_q[$];
    logic [NUM_CH-1:0]     hang_mask = '0;
    int                    start_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        check(name, busy, 0);
    endtask

    task automatic wait_starts(input int target, input string name);
        int n = 0;
        while (start_cnt < target && n < 200) begin
            tick();
            n++;
        end
        check(name, start_cnt >= target, 1);
    endtask

    // SAR core model: answers each start three cycles later unless the channel hangs.
    initial begin : sar_model
        logic            st;
        logic [CH_W-1:0] chs;
        int              pend = 0;
        sar_done   = 1'b0;
        sar_result = '0;
        forever begin
            @(negedge clk);
            st  = sar_start;
            chs = ch_sel;
            @(posedge clk);
            #1;
            sar_done = 1'b0;
            if (st) begin
                start_cnt++;
                if (exp_ch_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL start_unexpected: got ch %0d expected no start", chs);
                end else begin
                    check("start_ch", chs, exp_ch_q.pop_front());
                end
                if (!hang_mask[chs])
                    pend = 3;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    sar_done   = 1'b1;
                    sar_result = (code_q.size() > 0) ? code_q.pop_front() : '0;
                end
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst && res_valid && res_ready) begin
                if (exp_res_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL result_unexpected: got ch %0d data %0h expected none",
                             res_ch, res_data);
                end else begin
                    check("result", {res_ch, res_data}, exp_res_q.pop_front());
                end
            end
        end
    end

    initial begin : timeout_guard
        #200000;
        $display("FAIL sim_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin : stimulus
        int k, start_k, done_k, valid_k, s_cnt, starts0;
        logic samp_prev, samp_before, samp_at, seen_valid;

        rst = 1'b1; enable = 1'b0; continuous = 1'b0; trig = 1'b0;
        ch_mask = '0; res_ready = 1'b1;
        tick(3);
        check("rst_busy", busy, 0);
        check("rst_outs", {sample, sar_start, res_valid, overrun, timeout}, 0);
        check("rst_ch_sel", ch_sel, 0);
        check("rst_res", {res_ch, res_data}, 0);
        rst = 1'b0;
        enable = 1'b1;
        tick();

        // Single scan over channels 1 and 3.
        exp_ch_q.push_back(2'd1); exp_ch_q.push_back(2'd3);
        code_q.push_back(8'hA5);  code_q.push_back(8'h3C);
        exp_res_q.push_back({2'd1, 8'hA5}); exp_res_q.push_back({2'd3, 8'h3C});
        ch_mask = 4'b1010; trig = 1'b1;
        tick();
        trig = 1'b0;
        wait_idle("single_idle");
        starts0 = start_cnt;
        tick(10);
        check("single_no_restart", start_cnt, starts0);
        check("single_drained", exp_res_q.size(), 0);

        // Sample window and latency on channel 0.
        exp_ch_q.push_back(2'd0); code_q.push_back(8'h5A);
        exp_res_q.push_back({2'd0, 8'h5A});
        ch_mask = 4'b0001; trig = 1'b1;
        start_k = -1; done_k = -1; valid_k = -1; s_cnt = 0;
        samp_prev = 1'b0; samp_before = 1'b0; samp_at = 1'b1;
        for (k = 1; k <= 30; k++) begin
            tick();
            trig = 1'b0;
            if (sample) s_cnt++;
            if (sar_start && start_k < 0) begin
                start_k     = k;
                samp_before = samp_prev;
                samp_at     = sample;
            end
            if (sar_done && done_k < 0) done_k = k;
            if (res_valid && valid_k < 0) valid_k = k;
            samp_prev = sample;
        end
        check("trig_to_start", start_k, 6);
        check("sample_width", s_cnt, 4);
        check("sample_before_start", samp_before, 1);
        check("sample_at_start", samp_at, 0);
        check("done_to_valid", valid_k - done_k, 2);
        wait_idle("timing_idle");

        // Backpressure: four results, only the last survives.
        res_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            exp_ch_q.push_back(CH_W'(c));
            code_q.push_back(8'(8'h11 * (c + 1)));
        end
        exp_res_q.push_back({2'd3, 8'h44});
        ch_mask = 4'b1111; trig = 1'b1;
        tick();
        trig = 1'b0;
        k = 0;
        while (!res_valid && k < 100) begin
            tick();
            k++;
        end
        check("bp_first_valid", res_valid, 1);
        check("bp_no_overrun_yet", overrun, 0);
        wait_idle("bp_idle");
        check("bp_valid_held", res_valid, 1);
        check("bp_last_data", {res_ch, res_data}, {2'd3, 8'h44});
        check("bp_overrun", overrun, 1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        tick();
        check("bp_valid_cleared", res_valid, 0);
        res_ready = 1'b1;

        // Continuous scan 1,2,1,2 with enable dropped during the last conversion.
        exp_ch_q.push_back(2'd1); exp_ch_q.push_back(2'd2);
        exp_ch_q.push_back(2'd1); exp_ch_q.push_back(2'd2);
        code_q.push_back(8'h01); code_q.push_back(8'h02);
        code_q.push_back(8'h81); code_q.push_back(8'h82);
        exp_res_q.push_back({2'd1, 8'h01}); exp_res_q.push_back({2'd2, 8'h02});
        exp_res_q.push_back({2'd1, 8'h81}); exp_res_q.push_back({2'd2, 8'h82});
        ch_mask = 4'b0110; continuous = 1'b1;
        starts0 = start_cnt;
        wait_starts(starts0 + 4, "cont_starts");
        enable = 1'b0;
        wait_idle("cont_idle");
        tick(8);
        check("cont_busy_low", busy, 0);
        check("cont_drained", exp_res_q.size(), 0);
        continuous = 1'b0;
        enable = 1'b1;

        // Reset during a conversion; the late done must be ignored.
        exp_ch_q.push_back(2'd0); code_q.push_back(8'hEE);
        ch_mask = 4'b0001; trig = 1'b1;
        starts0 = start_cnt;
        tick();
        trig = 1'b0;
        wait_starts(starts0 + 1, "rstc_start");
        rst = 1'b1;
        tick();
        check("rstc_outs", {busy, sample, sar_start, res_valid, overrun, timeout}, 0);
        check("rstc_ch_sel", ch_sel, 0);
        rst = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (res_valid || busy) seen_valid = 1'b1;
        end
        check("rstc_late_done_ignored", seen_valid, 0);
        check("rstc_done_fired", code_q.size(), 0);

`ifdef SAR_WDOG_EN
        hang_mask = 4'b0001;
        exp_ch_q.push_back(2'd0); exp_ch_q.push_back(2'd1);
        code_q.push_back(8'h77);
        exp_res_q.push_back({2'd1, 8'h77});
        ch_mask = 4'b0011; trig = 1'b1;
        starts0 = start_cnt;
        tick();
        trig = 1'b0;
        wait_starts(starts0 + 1, "wdog_start");
        tick(14);
        check("wdog_not_yet", timeout, 0);
        tick();
        check("wdog_timeout", timeout, 1);
        wait_idle("wdog_idle");
        check("wdog_drained", exp_res_q.size(), 0);
        hang_mask = '0;
`endif

        tick(4);
        check("final_results_drained", exp_res_q.size(), 0);
        check("final_starts_drained", exp_ch_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
